fetch_queue: RTL and testbench
==============================

# fetch_queue

Prefetching instruction-fetch stage sitting between the instruction memory port and operand fetch. Holds a fetch PC, issues one word read per cycle to the synchronous instruction memory, and buffers returned {pc, inst} pairs in a small FIFO drained by the downstream stage through a valid/ready handshake. Branch redirects flush all buffered and in-flight words. A halt opcode stops further fetching and raises `stop` once drained.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0, fetch PC after reset.
- `HALT_OPCODE`, 5'b11111, value of `inst[31:27]` treated as halt.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `IMclka`  out  1  instruction memory clock; equals `clk`.
- `IMaddra`  out  7  word address; always `fpc[8:2]`.
- `IMdouta`  in  32  read data, valid one cycle after the address is sampled.
- `isBranchTaken`  in  1  redirect request.
- `branchPC`  in  32  redirect target.
- `outValid`  out  1  head entry valid.
- `outReady`  in  1  consumer accepts head this cycle.
- `outInst`  out  32  head instruction.
- `outPC`  out  32  PC of head instruction.
- `stop`  out  1  sticky; halt instruction has been consumed.

## Operation
- State: `fpc` (32 b), `inflight` (1 b) plus `inflightPC`, FIFO array with rd/wr pointers of log2(DEPTH) bits and `count` of log2(DEPTH)+1 bits, `halted`, `stop`.
- Reset (edge with `rst`=1): `fpc`=RESET_PC, count=0, pointers=0, inflight=0, halted=0, stop=0. Outputs: `outValid`=0, `stop`=0, `IMaddra`=RESET_PC[8:2], `outInst`/`outPC` don't-care while `outValid`=0.
- Issue condition at an edge: `!rst && !isBranchTaken && !halted && !stop && (count + inflight) < DEPTH`. On issue: inflight←1, inflightPC←fpc, fpc←fpc+4 (32-bit wrap; `IMaddra` wraps at 128 words).
- Capture: at an edge with inflight=1 and no flush, write {inflightPC, IMdouta} at wr pointer, count+1. inflight clears unless a new issue occurs on the same edge.
- If captured `IMdouta[31:27]`==HALT_OPCODE: halted←1 on that edge. No further issue. Words already in FIFO before it still drain.
- Dequeue: edge with `outValid && outReady`: rd pointer+1, count−1. If the dequeued instruction's opcode is HALT_OPCODE, stop←1 (sticky until `rst`).
- Simultaneous capture and dequeue: count unchanged; both pointers advance.
- Flush (edge with `isBranchTaken`=1, highest priority below reset): count←0, pointers←0, inflight←0 (returning word discarded), halted←0, fpc←branchPC. Any concurrent dequeue is void. No issue on that edge. `stop` is not cleared by a branch.
- `outValid` = (count != 0) && !stop.
- Credit rule guarantees no overflow: capture never finds FIFO full.

## Timing
- Memory latency 1 cycle. Cold start/redirect: address presented cycle C, sampled at edge E0, word captured at E1, `outValid`=1 in the cycle after E1 (2 edges after the first fetch-enabled edge).
- Sustained throughput 1 instruction/cycle with `outReady` held high and DEPTH≥2.
- Branch-to-first-valid: flush at edge Ef; `IMaddra`=branchPC[8:2] after Ef; issue at Ef+1; `outValid` after Ef+2.
- `rst` asserted mid-operation: next edge applies reset values regardless of other inputs.
- `outReady` low: FIFO fills to DEPTH, then issue stalls; no word lost or duplicated.

## Test plan
- Reset, RESET_PC=0, IM word k = 32'h1000_0000+k, `outReady`=1 -> `outValid` rises 2 edges after reset release; outPC 0,4,8,... with outInst 32'h1000_0000, 32'h1000_0001, ... one per cycle.
- `outReady`=0 for 10 cycles -> count saturates at 4, `IMaddra` frozen at word 4; on release entries 0..3 then 4.. appear in order, no gaps or repeats.
- Branch to 32'h40 while FIFO holds 3 entries and one in flight -> `outValid`=0 for 2 cycles, next outPC=32'h40, outInst = IM word 16.
- Halt opcode at word 3 -> words 0..3 delivered, no issue past word 4 address; `stop`=1 one edge after word 3 dequeued; `outValid` stays 0.
- PC at 32'h1FC continuing sequentially -> `IMaddra` wraps 127→0, outPC=32'h200 carries word 0.
- Assert `rst` with 2 entries buffered and branch pending -> next cycle `outValid`=0, `stop`=0, `IMaddra`=RESET_PC[8:2].

Source files
------------

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch stage: issues one word read per cycle to a
// synchronous instruction memory and buffers {pc, inst} pairs in a small FIFO.
module fetch_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [4:0]  HALT_OPCODE = 5'b11111
) (
    input  logic        clk,
    input  logic        rst,
    output logic        IMclka,
    output logic [6:0]  IMaddra,
    input  logic [31:0] IMdouta,
    input  logic        isBranchTaken,
    input  logic [31:0] branchPC,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outInst,
    output logic [31:0] outPC,
    output logic        stop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      fpc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic             halted;
    logic [31:0]      fifo_inst [DEPTH];
    logic [31:0]      fifo_pc   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic flush;
    logic issue;
    logic capture;
    logic deq;

    // Credit check counts the in-flight word so a capture never finds the FIFO full.
    always_comb begin
        flush   = isBranchTaken;
        issue   = !flush && !halted && !stop && ((32'(count) + 32'(inflight)) < DEPTH);
        capture = inflight && !flush;
        deq     = outValid && outReady && !flush;
    end

    assign IMclka   = clk;
    assign IMaddra  = fpc[8:2];
    assign outValid = (count != '0) && !stop;
    assign outInst  = fifo_inst[rd_ptr];
    assign outPC    = fifo_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc         <= RESET_PC;
            inflight_pc <= RESET_PC;
            inflight    <= 1'b0;
            halted      <= 1'b0;
            stop        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (flush) begin
            // Redirect discards buffered and returning words; stop stays sticky.
            fpc      <= branchPC;
            inflight <= 1'b0;
            halted   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                inflight_pc <= fpc;
                fpc         <= fpc + 32'd4;
            end
            inflight <= issue;
            if (capture) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (IMdouta[31:27] == HALT_OPCODE) begin
                    halted <= 1'b1;
                end
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (outInst[31:27] == HALT_OPCODE) begin
                    stop <= 1'b1;
                end
            end
            count <= count + CNT_W'(capture) - CNT_W'(deq);
        end
    end

    // FIFO storage needs no reset; contents are ignored while count is zero.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            fifo_inst[wr_ptr] <= IMdouta;
            fifo_pc[wr_ptr]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a per-cycle vector table for stream,
// back-pressure and redirect, then hand sequences for halt, wrap and reset.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_clk;
    logic [6:0]  im_addr;
    logic [31:0] im_dout;
    logic        br;
    logic [31:0] bpc;
    logic        out_valid;
    logic        ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        stop;

    logic [31:0] mem [128];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) im_dout <= mem[im_addr];

    fetch_queue #(
        .DEPTH(4),
        .RESET_PC(32'h0),
        .HALT_OPCODE(5'b11111)
    ) dut (
        .clk(clk),
        .rst(rst),
        .IMclka(im_clk),
        .IMaddra(im_addr),
        .IMdouta(im_dout),
        .isBranchTaken(br),
        .branchPC(bpc),
        .outValid(out_valid),
        .outReady(ready),
        .outInst(out_inst),
        .outPC(out_pc),
        .stop(stop)
    );

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] bpc;
        logic        ready;
        logic        ev;
        logic [31:0] epc;
        logic [6:0]  eaddr;
        logic        estop;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic r, input logic b, input logic [31:0] bp,
                                input logic rdy, input logic ev, input logic [31:0] epc,
                                input logic [6:0] ea, input logic es);
        vec_t v;
        v.rst = r; v.br = b; v.bpc = bp; v.ready = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = ea; v.estop = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic [31:0] bp, input logic rdy);
        @(negedge clk);
        rst = r; br = b; bpc = bp; ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [31:0] epc,
                              input logic [6:0] ea, input logic es);
        logic [31:0] einst;
        chk($sformatf("%s valid", tag), 32'(out_valid), 32'(ev));
        chk($sformatf("%s stop", tag), 32'(stop), 32'(es));
        chk($sformatf("%s addr", tag), 32'(im_addr), 32'(ea));
        if (ev) begin
            einst = mem[epc[8:2]];
            chk($sformatf("%s pc", tag), out_pc, epc);
            chk($sformatf("%s inst", tag), out_inst, einst);
        end
    endtask

    initial begin
        rst = 1'b1; br = 1'b0; bpc = 32'h0; ready = 1'b1;
        for (int k = 0; k < 128; k++) mem[k] = 32'h1000_0000 + 32'(k);

        // Stream, back-pressure saturation, then redirect with 3 buffered + 1 in flight.
        vecs[0]  = mk(1, 0, 32'h0,  1, 0, 32'h0,  7'd0,  0);
        vecs[1]  = mk(0, 0, 32'h0,  1, 0, 32'h0,  7'd1,  0);
        vecs[2]  = mk(0, 0, 32'h0,  1, 1, 32'h0,  7'd2,  0);
        vecs[3]  = mk(0, 0, 32'h0,  1, 1, 32'h4,  7'd3,  0);
        vecs[4]  = mk(0, 0, 32'h0,  1, 1, 32'h8,  7'd4,  0);
        vecs[5]  = mk(0, 0, 32'h0,  0, 1, 32'h8,  7'd5,  0);
        vecs[6]  = mk(0, 0, 32'h0,  0, 1, 32'h8,  7'd6,  0);
        vecs[7]  = mk(0, 0, 32'h0,  0, 1, 32'h8,  7'd6,  0);
        vecs[8]  = mk(0, 0, 32'h0,  0, 1, 32'h8,  7'd6,  0);
        vecs[9]  = mk(0, 0, 32'h0,  0, 1, 32'h8,  7'd6,  0);
        vecs[10] = mk(0, 0, 32'h0,  0, 1, 32'h8,  7'd6,  0);
        vecs[11] = mk(0, 0, 32'h0,  1, 1, 32'hC,  7'd6,  0);
        vecs[12] = mk(0, 0, 32'h0,  1, 1, 32'h10, 7'd7,  0);
        vecs[13] = mk(0, 0, 32'h0,  1, 1, 32'h14, 7'd8,  0);
        vecs[14] = mk(0, 0, 32'h0,  1, 1, 32'h18, 7'd9,  0);
        vecs[15] = mk(0, 0, 32'h0,  1, 1, 32'h1C, 7'd10, 0);
        vecs[16] = mk(0, 0, 32'h0,  0, 1, 32'h1C, 7'd11, 0);
        vecs[17] = mk(0, 1, 32'h40, 1, 0, 32'h0,  7'd16, 0);
        vecs[18] = mk(0, 0, 32'h0,  1, 0, 32'h0,  7'd17, 0);
        vecs[19] = mk(0, 0, 32'h0,  1, 1, 32'h40, 7'd18, 0);
        vecs[20] = mk(0, 0, 32'h0,  1, 1, 32'h44, 7'd19, 0);

        @(posedge clk);
        #1;
        chk("imclka high", 32'(im_clk), 32'd1);
        @(negedge clk);
        #1;
        chk("imclka low", 32'(im_clk), 32'd0);

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].br, vecs[i].bpc, vecs[i].ready);
            expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].eaddr, vecs[i].estop);
        end

        // Halt opcode at word 3: words 0..3 delivered, stop after word 3 leaves.
        mem[3] = 32'hF800_0003;
        step(1, 0, 32'h0, 1);   expect_out("halt rst", 0, 32'h0, 7'd0, 0);
        step(0, 0, 32'h0, 1);   expect_out("halt c1",  0, 32'h0, 7'd1, 0);
        step(0, 0, 32'h0, 1);   expect_out("halt c2",  1, 32'h0, 7'd2, 0);
        step(0, 0, 32'h0, 1);   expect_out("halt c3",  1, 32'h4, 7'd3, 0);
        step(0, 0, 32'h0, 1);   expect_out("halt c4",  1, 32'h8, 7'd4, 0);
        step(0, 0, 32'h0, 1);   expect_out("halt c5",  1, 32'hC, 7'd5, 0);
        step(0, 0, 32'h0, 1);   expect_out("halt c6",  0, 32'h0, 7'd5, 1);
        step(0, 0, 32'h0, 1);   expect_out("halt c7",  0, 32'h0, 7'd5, 1);
        step(0, 0, 32'h0, 1);   expect_out("halt c8",  0, 32'h0, 7'd5, 1);
        // A redirect moves fpc but leaves stop set and fetch idle.
        step(0, 1, 32'h100, 1); expect_out("halt br",  0, 32'h0, 7'd64, 1);
        step(0, 0, 32'h0, 1);   expect_out("halt br1", 0, 32'h0, 7'd64, 1);
        mem[3] = 32'h1000_0003;

        // Sequential fetch across the 128-word address wrap.
        step(1, 0, 32'h0, 1);   expect_out("wrap rst", 0, 32'h0,   7'd0,   0);
        step(0, 1, 32'h1FC, 1); expect_out("wrap br",  0, 32'h0,   7'd127, 0);
        step(0, 0, 32'h0, 1);   expect_out("wrap c1",  0, 32'h0,   7'd0,   0);
        step(0, 0, 32'h0, 1);   expect_out("wrap c2",  1, 32'h1FC, 7'd1,   0);
        step(0, 0, 32'h0, 1);   expect_out("wrap c3",  1, 32'h200, 7'd2,   0);
        step(0, 0, 32'h0, 1);   expect_out("wrap c4",  1, 32'h204, 7'd3,   0);
        step(0, 0, 32'h0, 0);   expect_out("wrap c5",  1, 32'h204, 7'd4,   0);

        // Reset with 2 entries buffered and a branch on the same edge.
        step(1, 1, 32'h80, 1);  expect_out("midrst",    0, 32'h0, 7'd0, 0);
        step(0, 0, 32'h0, 1);   expect_out("midrst c1", 0, 32'h0, 7'd1, 0);
        step(0, 0, 32'h0, 1);   expect_out("midrst c2", 1, 32'h0, 7'd2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
